// File: rtl/uart_tx_buffered_if.sv
// picorv32 native-bus slave port of the buffered UART transmitter.
// The master side also drives the decoder's slave-select enable.
interface uart_tx_buffered_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a byte FIFO that a
// baud-rate FSM drains LSB first; STATUS exposes FIFO state and sticky overflow.
module uart_tx_buffered #(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                resn,
  uart_tx_buffered_if.slave   bus,
  output logic                serial_out
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2:0]         bit_idx, bit_idx_n;
  logic [7:0]         shift, shift_n;
  logic               line_n;

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, overflow;

  logic               req, push_req, push, drop, pop, status_rd;
  logic [31:0]        status;

  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty = (count == '0);

  assign req       = bus.enable & bus.mem_valid & ~bus.mem_ready;
  assign push_req  = req & ~bus.mem_addr[2] & bus.mem_wstrb[0];
  assign status_rd = req & bus.mem_addr[2] & ~(|bus.mem_wstrb);
  // Fullness is judged after a same-cycle pop, so a push racing a pop is kept.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_comb begin
    status                 = '0;
    status[0]              = full;
    status[1]              = empty;
    status[2]              = (state != IDLE);
    status[3]              = overflow;
    status[8+FIFO_AW:8]    = count;
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
    end else begin
      bus.mem_ready <= req;
      bus.mem_rdata <= status_rd ? status : '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
      if (drop)           overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      serial_out <= line_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    line_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          cnt_n   = CNT_LOAD;
          state_n = START;
        end
      end
      START: begin
        line_n = 1'b0;
        if (cnt == '0) begin
          cnt_n     = CNT_LOAD;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        line_n = shift[0];
        if (cnt == '0) begin
          cnt_n   = CNT_LOAD;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = fifo_mem[rd_ptr];
            cnt_n   = CNT_LOAD;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.mem_instr, bus.mem_wstrb[3:1], bus.mem_wdata[31:8],
                             bus.mem_addr[31:3], bus.mem_addr[1:0]};

endmodule
